// File: rtl/motor602_gate_monitor.sv
// Gate-drive monitor for the motor602 3-phase bridge.
// Decodes the six gate lines back into a six-step index, direction, running
// state and electrical period, and raises sticky protection faults.
module motor602_gate_monitor #(
    parameter bit LOW_INV  = 1'b1,
    parameter int DEAD_MIN = 4,
    parameter int PW       = 24,
    parameter int TO_CYC   = 1000000
) (
    input  logic          clkI,
    input  logic          nRstI,
    input  logic          aHPi,
    input  logic          aLNi,
    input  logic          bHPi,
    input  logic          bLNi,
    input  logic          cHPi,
    input  logic          cLNi,
    input  logic          clrFaultI,
    output logic [2:0]    stepO,
    output logic          stepValidO,
    output logic          dirO,
    output logic          runningO,
    output logic [PW-1:0] periodO,
    output logic          periodValidO,
    output logic          shootFaultO,
    output logic          deadFaultO,
    output logic          seqFaultO
);
    localparam int DW = $clog2(DEAD_MIN + 1);
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [DW-1:0] DEAD_SAT = DW'(DEAD_MIN);
    localparam logic [TW-1:0] TO_MAX   = TW'(TO_CYC);
    localparam logic [PW-1:0] P_MAX    = '1;

    // bit 0 = phase A, bit 1 = phase B, bit 2 = phase C; 1 = FET conducting
    logic [2:0] h_q, l_q, l_pin;
    logic [5:0] hl;
    logic       one_h, one_l, is_step, is_hold, shoot;
    logic [2:0] dec, fwd, rev, step_n, run_q, run_n;
    logic       vld_n, dir_n, legal, seq_set, enter0;
    logic [TW-1:0] to_q, to_n;
    logic [PW-1:0] pcnt_q, pcnt_inc;
    logic [2:0][DW-1:0] off_q;
    logic [2:0] last_h, last_l;
    logic       dead_set;

    assign l_pin = {cLNi, bLNi, aLNi};

    // Register the gate pins once, normalising low-side polarity to "1 = on".
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            h_q <= '0;
            l_q <= '0;
        end else begin
            h_q <= {cHPi, bHPi, aHPi};
            l_q <= LOW_INV ? ~l_pin : l_pin;
        end
    end

    // Classify the registered switch pattern: legal step, hold or invalid.
    always_comb begin
        hl      = {h_q, l_q};
        one_h   = (h_q != 3'd0) && ((h_q & (h_q - 3'd1)) == 3'd0);
        one_l   = (l_q != 3'd0) && ((l_q & (l_q - 3'd1)) == 3'd0);
        shoot   = |(h_q & l_q);
        is_step = one_h && one_l && !shoot;
        // zero or one switch on: PWM chop or dead-time gap
        is_hold = (hl & (hl - 6'd1)) == 6'd0;
        case ({h_q, l_q})
            6'b001_010: dec = 3'd0;
            6'b001_100: dec = 3'd1;
            6'b010_100: dec = 3'd2;
            6'b010_001: dec = 3'd3;
            6'b100_001: dec = 3'd4;
            6'b100_010: dec = 3'd5;
            default:    dec = 3'd0;
        endcase
        fwd = (stepO == 3'd5) ? 3'd0 : stepO + 3'd1;
        rev = (stepO == 3'd0) ? 3'd5 : stepO - 3'd1;
    end

    // Sequence tracking: direction, run length, timeout and step-0 entry.
    always_comb begin
        step_n  = stepO;
        vld_n   = stepValidO;
        dir_n   = dirO;
        run_n   = run_q;
        legal   = 1'b0;
        seq_set = 1'b0;
        enter0  = 1'b0;
        if (!is_step && !is_hold) begin
            vld_n   = 1'b0;
            run_n   = 3'd0;
            seq_set = !shoot;
        end else if (is_step) begin
            step_n = dec;
            vld_n  = 1'b1;
            if (!stepValidO) begin
                // first decode after reset/invalid: nothing to compare against
                run_n  = 3'd0;
                enter0 = (dec == 3'd0);
            end else if (dec != stepO) begin
                enter0 = (dec == 3'd0);
                if (dec == fwd || dec == rev) begin
                    legal = 1'b1;
                    dir_n = (dec == fwd);
                    // a reversal starts a fresh run of one transition
                    if (dir_n == dirO)
                        run_n = (run_q == 3'd7) ? run_q : run_q + 3'd1;
                    else
                        run_n = 3'd1;
                end else begin
                    seq_set = 1'b1;
                    run_n   = 3'd0;
                end
            end
        end
        to_n = legal ? '0 : ((to_q == TO_MAX) ? to_q : to_q + TW'(1));
        if (!legal && to_n == TO_MAX)
            run_n = 3'd0;
        pcnt_inc = (pcnt_q == P_MAX) ? P_MAX : pcnt_q + PW'(1);
    end

    // Dead-time check: flag a turn-on that follows the opposite switch too soon.
    always_comb begin
        dead_set = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (off_q[p] < DEAD_SAT && ((h_q[p] && last_l[p]) || (l_q[p] && last_h[p])))
                dead_set = 1'b1;
        end
    end

    // Per-phase off-time counters and last-conducting-switch memory.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            off_q  <= '0;
            last_h <= '0;
            last_l <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (h_q[p] || l_q[p])
                    off_q[p] <= '0;
                else if (off_q[p] != DEAD_SAT)
                    off_q[p] <= off_q[p] + DW'(1);
                if (h_q[p] && !l_q[p]) begin
                    last_h[p] <= 1'b1;
                    last_l[p] <= 1'b0;
                end else if (l_q[p] && !h_q[p]) begin
                    last_h[p] <= 1'b0;
                    last_l[p] <= 1'b1;
                end
            end
        end
    end

    // Status registers, period measurement and sticky faults.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            stepO        <= '0;
            stepValidO   <= 1'b0;
            dirO         <= 1'b0;
            runningO     <= 1'b0;
            run_q        <= '0;
            to_q         <= '0;
            pcnt_q       <= '0;
            periodO      <= '0;
            periodValidO <= 1'b0;
            shootFaultO  <= 1'b0;
            deadFaultO   <= 1'b0;
            seqFaultO    <= 1'b0;
        end else begin
            stepO        <= step_n;
            stepValidO   <= vld_n;
            dirO         <= dir_n;
            run_q        <= run_n;
            runningO     <= (run_n >= 3'd2);
            to_q         <= to_n;
            pcnt_q       <= enter0 ? '0 : pcnt_inc;
            // six uninterrupted same-direction steps make a full revolution
            periodValidO <= enter0 && (run_n >= 3'd6);
            if (enter0 && run_n >= 3'd6)
                periodO <= pcnt_inc;
            // a new fault in the clear cycle wins
            shootFaultO  <= shoot    | (shootFaultO & ~clrFaultI);
            deadFaultO   <= dead_set | (deadFaultO  & ~clrFaultI);
            seqFaultO    <= seq_set  | (seqFaultO   & ~clrFaultI);
        end
    end

endmodule

// File: tb/tb_motor602_gate_monitor.sv
// Directed self-checking bench for motor602_gate_monitor (LOW_INV=1, DEAD_MIN=4, TO_CYC=150).
module tb_motor602_gate_monitor;
    localparam int PW = 24;

    logic          clkI = 1'b0;
    logic          nRstI = 1'b0;
    logic          aHPi = 1'b0, aLNi = 1'b1, bHPi = 1'b0, bLNi = 1'b1, cHPi = 1'b0, cLNi = 1'b1;
    logic          clrFaultI = 1'b0;
    logic [2:0]    stepO;
    logic          stepValidO, dirO, runningO, periodValidO;
    logic [PW-1:0] periodO;
    logic          shootFaultO, deadFaultO, seqFaultO;

    int passes = 0;
    int total  = 0;
    int pv_cnt = 0;
    int flt_cnt = 0;

    motor602_gate_monitor #(.LOW_INV(1'b1), .DEAD_MIN(4), .PW(PW), .TO_CYC(150)) dut (
        .clkI(clkI), .nRstI(nRstI),
        .aHPi(aHPi), .aLNi(aLNi), .bHPi(bHPi), .bLNi(bLNi), .cHPi(cHPi), .cLNi(cLNi),
        .clrFaultI(clrFaultI),
        .stepO(stepO), .stepValidO(stepValidO), .dirO(dirO), .runningO(runningO),
        .periodO(periodO), .periodValidO(periodValidO),
        .shootFaultO(shootFaultO), .deadFaultO(deadFaultO), .seqFaultO(seqFaultO)
    );

    // 10 MHz clock
    always #50 clkI = ~clkI;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // one clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clkI);
        #1;
        pv_cnt += int'(periodValidO);
        if (shootFaultO || deadFaultO || seqFaultO) flt_cnt++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // h/l are {C,B,A} "switch on" masks; low-side pins are active-low
    task automatic drive(input logic [2:0] h, input logic [2:0] l);
        {cHPi, bHPi, aHPi} = h;
        {cLNi, bLNi, aLNi} = ~l;
    endtask

    task automatic drive_step(input int s);
        case (s)
            0:       drive(3'b001, 3'b010);
            1:       drive(3'b001, 3'b100);
            2:       drive(3'b010, 3'b100);
            3:       drive(3'b010, 3'b001);
            4:       drive(3'b100, 3'b001);
            default: drive(3'b100, 3'b010);
        endcase
    endtask

    task automatic run_step(input int s, input int nact);
        drive_step(s);
        ticks(nact);
        chk($sformatf("step%0d", s), 32'(stepO), 32'(s));
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_step"},  32'(stepO), 0);
        chk({pfx, "_vld"},   32'(stepValidO), 0);
        chk({pfx, "_dir"},   32'(dirO), 0);
        chk({pfx, "_run"},   32'(runningO), 0);
        chk({pfx, "_per"},   32'(periodO), 0);
        chk({pfx, "_pv"},    32'(periodValidO), 0);
        chk({pfx, "_shoot"}, 32'(shootFaultO), 0);
        chk({pfx, "_dead"},  32'(deadFaultO), 0);
        chk({pfx, "_seq"},   32'(seqFaultO), 0);
    endtask

    initial begin
        bit found;

        // reset state
        ticks(3);
        chk_all_zero("rst");
        nRstI = 1'b1;
        ticks(5);

        // forward rotation: 96 driven + 4 idle = 100 clocks per step
        pv_cnt = 0;
        flt_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 6; s++) begin
                run_step(s, 96);
                chk($sformatf("fwd_run_r%0d_s%0d", r, s), 32'(runningO),
                    32'((r > 0 || s >= 2) ? 1 : 0));
                drive(3'b000, 3'b000);
                ticks(4);
            end
        end
        run_step(0, 96);
        drive(3'b000, 3'b000);
        ticks(4);
        chk("fwd_dir", 32'(dirO), 1);
        chk("fwd_pv_count", 32'(pv_cnt), 3);
        chk("fwd_period", 32'(periodO), 600);
        chk("fwd_faults", 32'(flt_cnt), 0);

        // reverse with wrap 0 -> 5 -> ... -> 0; 20 driven + 6 idle per step
        for (int s = 5; s >= 0; s--) begin
            run_step(s, 20);
            chk($sformatf("rev_dir_s%0d", s), 32'(dirO), 0);
            drive(3'b000, 3'b000);
            ticks(6);
        end
        chk("rev_seq", 32'(seqFaultO), 0);
        chk("rev_running", 32'(runningO), 1);
        // step-0 entries 100 + 5*26 clocks apart
        chk("rev_period", 32'(periodO), 230);

        // illegal jump 2 -> 4, then no period update at the next step-0 entry
        run_step(1, 20); drive(3'b000, 3'b000); ticks(6);
        run_step(2, 20); drive(3'b000, 3'b000); ticks(6);
        chk("pre_jump_seq", 32'(seqFaultO), 0);
        pv_cnt = 0;
        run_step(4, 20);
        chk("jump_seq", 32'(seqFaultO), 1);
        drive(3'b000, 3'b000); ticks(6);
        run_step(5, 20); drive(3'b000, 3'b000); ticks(6);
        run_step(0, 20); drive(3'b000, 3'b000); ticks(6);
        chk("jump_no_pv", 32'(pv_cnt), 0);
        chk("jump_period_kept", 32'(periodO), 230);
        clrFaultI = 1'b1;
        tick();
        clrFaultI = 1'b0;
        chk("seq_cleared", 32'(seqFaultO), 0);

        // shoot-through on phase A for one clock
        drive(3'b000, 3'b000);
        ticks(10);
        drive(3'b001, 3'b001);
        tick();
        drive(3'b000, 3'b000);
        chk("shoot_lag1", 32'(shootFaultO), 0);
        tick();
        chk("shoot_set", 32'(shootFaultO), 1);
        chk("shoot_no_seq", 32'(seqFaultO), 0);
        chk("shoot_no_dead", 32'(deadFaultO), 0);
        chk("shoot_step_invalid", 32'(stepValidO), 0);
        ticks(3);
        chk("shoot_sticky", 32'(shootFaultO), 1);
        clrFaultI = 1'b1;
        tick();
        clrFaultI = 1'b0;
        chk("shoot_cleared", 32'(shootFaultO), 0);

        // dead-time on phase B: H off, 2 idle, L on -> fault
        drive(3'b010, 3'b000); ticks(5);
        drive(3'b000, 3'b000); ticks(2);
        drive(3'b000, 3'b010); ticks(3);
        chk("dead_short", 32'(deadFaultO), 1);
        drive(3'b000, 3'b000); ticks(8);
        clrFaultI = 1'b1;
        tick();
        clrFaultI = 1'b0;
        chk("dead_cleared", 32'(deadFaultO), 0);
        // 4 idle clocks meet the minimum
        drive(3'b010, 3'b000); ticks(5);
        drive(3'b000, 3'b000); ticks(4);
        drive(3'b000, 3'b010); ticks(3);
        chk("dead_ok", 32'(deadFaultO), 0);
        drive(3'b000, 3'b000); ticks(8);
        // chopping the same switch with a 1-clock gap
        drive(3'b010, 3'b000); ticks(5);
        drive(3'b000, 3'b000); ticks(1);
        drive(3'b010, 3'b000); ticks(3);
        chk("dead_chop", 32'(deadFaultO), 0);
        chk("chop_seq", 32'(seqFaultO), 0);
        drive(3'b000, 3'b000); ticks(10);

        // timeout: reach running, then hold step 3
        run_step(1, 20); drive(3'b000, 3'b000); ticks(6);
        run_step(2, 20); drive(3'b000, 3'b000); ticks(6);
        drive_step(3);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            if (stepO == 3'd3) found = 1'b1;
        end
        chk("to_step3_seen", 32'(found), 1);
        chk("to_running_start", 32'(runningO), 1);
        ticks(149);
        chk("to_running_149", 32'(runningO), 1);
        tick();
        chk("to_running_150", 32'(runningO), 0);
        chk("to_period_kept", 32'(periodO), 230);
        chk("to_step_held", 32'(stepO), 3);

        // reset mid-run
        run_step(4, 20); drive(3'b000, 3'b000); ticks(6);
        run_step(5, 20);
        chk("pre_rst_running", 32'(runningO), 1);
        nRstI = 1'b0;
        tick();
        chk_all_zero("mid_rst");
        nRstI = 1'b1;
        drive_step(2);
        ticks(2);
        chk("post_rst_step", 32'(stepO), 2);
        chk("post_rst_vld", 32'(stepValidO), 1);
        chk("post_rst_seq", 32'(seqFaultO), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
